// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_be byte-enable RAM macro.
package ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  localparam int RDW_READ_FIRST  = 32'sd0;
  localparam int RDW_WRITE_FIRST = 32'sd1;

  function automatic int byte_count(input int data_width);
    return data_width / 32'sd8;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset zero-fill sequencer: walks every word address once, then parks in READY.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32'sd12
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_clr_we,
  output logic [ADDR_WIDTH-1:0] o_clr_addr,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // Next-state and sweep counter; READY is only left through reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_ONE;
        if (cnt_q == ADDR_LAST) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = ADDR_ZERO;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= ADDR_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_clr_we   = (state_q == ST_CLEAR);
  assign o_clr_addr = cnt_q;
  assign o_done     = (state_q == ST_READY);

endmodule

// File: rtl/ram_be.sv
// Single-port synchronous RAM with byte enables, req/ready handshake and in-order responses.
// Define RAM_CLEAR_EN to zero-fill the whole array after every reset before accepting traffic.
module ram_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32'sd32,
  parameter int ADDR_WIDTH = 32'sd12,
  parameter int RDW_MODE   = RDW_READ_FIRST,
  parameter int OUT_REG    = 32'sd0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req,
  output logic                    o_ready,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wrdata,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_rvalid,
  output logic                    o_busy
);

  localparam int                    BE_W      = byte_count(DATA_WIDTH);
  localparam int                    DEPTH     = 32'sd1 << ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ready;
  logic                  accept;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] rsp_word;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BE_W-1:0]       mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;

`ifdef RAM_CLEAR_EN
  logic clr_done;

  ram_clear_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .o_clr_we   (clr_we),
    .o_clr_addr (clr_addr),
    .o_done     (clr_done)
  );

  assign ready  = clr_done;
  assign o_busy = ~clr_done;
`else
  assign clr_we   = 1'b0;
  assign clr_addr = {ADDR_WIDTH{1'b0}};
  assign ready    = 1'b1;
  assign o_busy   = 1'b0;
`endif

  assign o_ready = ready;
  assign accept  = i_req & ready;

  // Byte merge and response selection; the old word is read combinationally so a
  // write followed immediately by a read of the same address never sees stale data.
  always_comb begin
    old_word = mem[i_addr];
    merged   = old_word;
    for (int k = 0; k < BE_W; k++) begin
      if (i_be[k]) begin
        merged[8*k +: 8] = i_wrdata[8*k +: 8];
      end else begin
        merged[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    if (i_we && (RDW_MODE == RDW_WRITE_FIRST)) begin
      rsp_word = merged;
    end else begin
      rsp_word = old_word;
    end
  end

  // Array port mux: the clear sweep owns the port while it runs.
  always_comb begin
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_be    = {BE_W{1'b1}};
      mem_wdata = WORD_ZERO;
    end else begin
      mem_we    = accept & i_we;
      mem_addr  = i_addr;
      mem_be    = i_be;
      mem_wdata = i_wrdata;
    end
  end

  // Storage array, deliberately outside reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (mem_be[k]) begin
          mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
      end
    end
  end

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  tail_valid;
  logic [DATA_WIDTH-1:0] tail_data;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Capture the response word at the accepting edge.
  always_comb begin
    s1_valid_d = accept;
    if (accept) begin
      s1_data_d = rsp_word;
    end else begin
      s1_data_d = s1_data_q;
    end
  end

  // First response stage register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= WORD_ZERO;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  s2_valid_q, s2_valid_d;
      logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

      // Extra pipeline stage for timing-critical consumers.
      always_comb begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_data_d = s1_data_q;
        end else begin
          s2_data_d = s2_data_q;
        end
      end

      // Second response stage register.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= WORD_ZERO;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign tail_valid = s2_valid_q;
      assign tail_data  = s2_data_q;
    end else begin : g_no_out_reg
      assign tail_valid = s1_valid_q;
      assign tail_data  = s1_data_q;
    end
  endgenerate

  // Output data holds the last response between pulses.
  always_comb begin
    rvalid_d = tail_valid;
    if (tail_valid) begin
      rdata_d = tail_data;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Registered response outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= WORD_ZERO;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_rvalid = rvalid_q;
  assign o_rdata  = rdata_q;

endmodule

// File: tb/tb_ram_be.sv
// Bench for ram_be: two instances (read-first/no out reg, write-first/out reg) on shared stimulus.
module tb_ram_be;

  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] FULL  = 32'hFFFF_FFFF;
`ifdef RAM_CLEAR_EN
  localparam bit          CLR   = 1'b1;
`else
  localparam bit          CLR   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic        rdy0, rdy1, rv0, rv1, busy0, busy1;
  logic [31:0] rd0, rd1;

  always #5 clk = ~clk;

  ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .RDW_MODE(0), .OUT_REG(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_ready(rdy0), .i_we(we), .i_be(be),
    .i_addr(addr), .i_wrdata(wdata), .o_rdata(rd0), .o_rvalid(rv0), .o_busy(busy0));

  ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .RDW_MODE(1), .OUT_REG(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_ready(rdy1), .i_we(we), .i_be(be),
    .i_addr(addr), .i_wrdata(wdata), .o_rdata(rd1), .o_rvalid(rv1), .o_busy(busy1));

  int total = 0;
  int bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp, input logic [31:0] msk);
    total++;
    if ((act & msk) !== (exp & msk)) begin
      bad++;
      $display("FAIL %s: got %h want %h (mask %h) t=%0t", nm, act, exp, msk, $time);
    end
  endfunction

  // Reference model: word array with a known-bit mask, plus per-instance response queues.
  typedef struct { logic [31:0] d; logic [31:0] m; int due; } rsp_t;
  rsp_t        q0[$];
  rsp_t        q1[$];
  logic [31:0] mm [DEPTH];
  logic [31:0] mk [DEPTH];
  logic [31:0] last0, last1, lm0, lm1, old_w, mrg_w, bm;
  int          cyc = 0;
  int          sweep = 0;
  int          pulses1 = 0;
  bit          er, ev0, ev1;
  rsp_t        e0, e1;

  initial begin
    last0 = 32'h0; last1 = 32'h0; lm0 = FULL; lm1 = FULL;
    for (int a = 0; a < DEPTH; a++) begin
      mm[a] = 32'h0;
      mk[a] = 32'h0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) sweep = 0;
      er = CLR ? (sweep >= DEPTH) : 1'b1;
      chk("ready0", 32'(rdy0), 32'(er), FULL);
      chk("ready1", 32'(rdy1), 32'(er), FULL);
      chk("busy0", 32'(busy0), 32'(CLR && !er), FULL);
      chk("busy1", 32'(busy1), 32'(CLR && !er), FULL);
      if (!rst_n) begin
        q0.delete();
        q1.delete();
        last0 = 32'h0; last1 = 32'h0; lm0 = FULL; lm1 = FULL;
        chk("rst_rvalid0", 32'(rv0), 32'h0, FULL);
        chk("rst_rvalid1", 32'(rv1), 32'h0, FULL);
        chk("rst_rdata0", rd0, 32'h0, FULL);
        chk("rst_rdata1", rd1, 32'h0, FULL);
      end else begin
        ev0 = (q0.size() > 0) && (q0[0].due == cyc);
        ev1 = (q1.size() > 0) && (q1[0].due == cyc);
        if (ev0) begin last0 = q0[0].d; lm0 = q0[0].m; void'(q0.pop_front()); end
        if (ev1) begin last1 = q1[0].d; lm1 = q1[0].m; void'(q1.pop_front()); end
        if (rv1) pulses1++;
        chk("rvalid0", 32'(rv0), 32'(ev0), FULL);
        chk("rvalid1", 32'(rv1), 32'(ev1), FULL);
        chk("rdata0", rd0, last0, lm0);
        chk("rdata1", rd1, last1, lm1);
        if (req && er) begin
          old_w = mm[addr];
          for (int k = 0; k < 4; k++) bm[8*k +: 8] = {8{be[k]}};
          mrg_w = (old_w & ~bm) | (wdata & bm);
          e0.d = old_w; e0.m = mk[addr]; e0.due = cyc + 2;
          e1 = e0; e1.due = cyc + 3;
          if (we) begin
            e1.d = mrg_w;
            e1.m = mk[addr] | bm;
            mm[addr] = mrg_w;
            mk[addr] = mk[addr] | bm;
          end
          q0.push_back(e0);
          q1.push_back(e1);
        end
        if (CLR && sweep < DEPTH) begin
          sweep++;
          if (sweep == DEPTH) begin
            for (int a = 0; a < DEPTH; a++) begin
              mm[a] = 32'h0;
              mk[a] = FULL;
            end
          end
        end
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [3:0] b,
                       input logic [3:0] a, input logic [31:0] d);
    req = r; we = w; be = b; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  // Single request, then literal check of both held responses.
  task automatic one(input string nm, input logic w, input logic [3:0] b, input logic [3:0] a,
                     input logic [31:0] d, input logic [31:0] x0, input logic [31:0] x1);
    drive(1'b1, w, b, a, d);
    idle(3);
    chk({nm, "_rf"}, rd0, x0, FULL);
    chk({nm, "_wf"}, rd1, x1, FULL);
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++)
      drive($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 4'($urandom), $urandom);
    idle(4);
  endtask

  task automatic wait_sweep();
`ifdef RAM_CLEAR_EN
    repeat (15) @(posedge clk);
    #1;
    chk("sweep15_ready", 32'(rdy0), 32'h0, FULL);
    @(posedge clk);
    #1;
    chk("sweep16_ready", 32'(rdy0), 32'h1, FULL);
    chk("sweep16_busy", 32'(busy0), 32'h0, FULL);
`else
    @(posedge clk);
    #1;
`endif
  endtask

  int p0;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`ifdef RAM_CLEAR_EN
    chk("rst_ready_lit", 32'(rdy0), 32'h0, FULL);
    chk("rst_busy_lit", 32'(busy0), 32'h1, FULL);
`else
    chk("rst_ready_lit", 32'(rdy0), 32'h1, FULL);
    chk("rst_busy_lit", 32'(busy0), 32'h0, FULL);
`endif
    rst_n = 1'b1;
`ifdef RAM_CLEAR_EN
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midsweep_busy", 32'(busy0), 32'h1, FULL);
    chk("midsweep_ready", 32'(rdy0), 32'h0, FULL);
    chk("midsweep_rvalid", 32'(rv0), 32'h0, FULL);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_sweep();
`else
    for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b1, 4'hF, 4'(a), 32'h0);
    idle(3);
`endif
    for (int a = 0; a < DEPTH; a++) one("zero", 1'b0, 4'h0, 4'(a), 32'h0, 32'h0, 32'h0);

    one("wr3_full", 1'b1, 4'hF, 4'h3, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF);
    one("wr3_byte2", 1'b1, 4'b0100, 4'h3, 32'h00AA_0000, 32'hDEAD_BEEF, 32'hDEAA_BEEF);
    one("rd3", 1'b0, 4'h0, 4'h3, 32'h0, 32'hDEAA_BEEF, 32'hDEAA_BEEF);
    one("wr5_a", 1'b1, 4'hF, 4'h5, 32'h1111_1111, 32'h0, 32'h1111_1111);
    one("wr5_b", 1'b1, 4'hF, 4'h5, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222);
    one("wr2", 1'b1, 4'hF, 4'h2, 32'h1234_5678, 32'h0, 32'h1234_5678);
    one("wr2_be0", 1'b1, 4'h0, 4'h2, 32'hCAFE_F00D, 32'h1234_5678, 32'h1234_5678);
    one("rd2", 1'b0, 4'h0, 4'h2, 32'h0, 32'h1234_5678, 32'h1234_5678);

    drive(1'b1, 1'b1, 4'hF, 4'h9, 32'hA5A5_A5A5);
    drive(1'b1, 1'b0, 4'h0, 4'h9, 32'h0);
    idle(3);
    chk("wr_rd_rf", rd0, 32'hA5A5_A5A5, FULL);
    chk("wr_rd_wf", rd1, 32'hA5A5_A5A5, FULL);

    p0 = pulses1;
    for (int a = 0; a < 8; a++) drive(1'b1, 1'b0, 4'h0, 4'(a), 32'h0);
    idle(4);
    chk("stream_pulses", 32'(pulses1 - p0), 32'd8, FULL);

    drive(1'b1, 1'b0, 4'h0, 4'h3, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 4'h2, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("midrsp_rvalid0", 32'(rv0), 32'h0, FULL);
    chk("midrsp_rvalid1", 32'(rv1), 32'h0, FULL);
    chk("midrsp_rdata1", rd1, 32'h0, FULL);
    req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_sweep();
`ifdef RAM_CLEAR_EN
    one("rd3_after_rst", 1'b0, 4'h0, 4'h3, 32'h0, 32'h0, 32'h0);
`else
    one("rd3_after_rst", 1'b0, 4'h0, 4'h3, 32'h0, 32'hDEAA_BEEF, 32'hDEAA_BEEF);
`endif

    rand_phase(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
